// File: rtl/cm0_pkg.sv
// Shared definitions for the Cortex-M0 load/store-multiple sequencer.
package cm0_pkg;

  localparam int unsigned LIST_W = 10;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    OP_STM  = 2'b00,
    OP_LDM  = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_XFER,
    ST_WB,
    ST_DONE
  } state_e;

  // List bit position -> architectural register index (bit 8 = LR, bit 9 = PC).
  function automatic logic [3:0] list_bit_to_reg(input int unsigned pos);
    if (pos < 8) begin
      return 4'(pos);
    end else if (pos == 8) begin
      return REG_LR;
    end else begin
      return REG_PC;
    end
  endfunction

  function automatic logic op_is_load(input op_e op);
    return (op == OP_LDM) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/ldm_stm_seq_list_pick.sv
// Combinational register-list helper: lowest set entry, remainder, popcount.
module list_pick #(
  parameter int unsigned LIST_W = cm0_pkg::LIST_W
) (
  input  logic [LIST_W-1:0] list_i,
  output logic [3:0]        idx_o,
  output logic [LIST_W-1:0] rest_o,
  output logic [3:0]        cnt_o
);
  import cm0_pkg::*;

  logic found;

  // Scan from bit 0 upward: first hit is the next register, all hits are counted.
  always_comb begin
    found  = 1'b0;
    idx_o  = '0;
    rest_o = list_i;
    cnt_o  = '0;
    for (int unsigned i = 0; i < LIST_W; i++) begin
      if (list_i[i]) begin
        cnt_o = cnt_o + 4'd1;
        if (!found) begin
          found     = 1'b1;
          idx_o     = list_bit_to_reg(i);
          rest_o[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM/PUSH/POP sequencer: walks the register list one word per memory
// handshake, then writes back the updated base register.
module ldm_stm_seq #(
  parameter int unsigned LIST_W = cm0_pkg::LIST_W,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LIST_W-1:0] list,
  input  logic [3:0]        rn_idx,
  input  logic [ADDR_W-1:0] rn_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [3:0]        rf_raddr,
  input  logic [ADDR_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [ADDR_W-1:0] rf_wdata,
  output logic              pc_load,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import cm0_pkg::*;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [LIST_W-1:0] list_q, list_d;
  logic [3:0]        rn_idx_q, rn_idx_d;
  logic [ADDR_W-1:0] rn_val_q, rn_val_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic              err_q, err_d;
  logic              skip_wb_q, skip_wb_d;

  logic [3:0]        pick_idx;
  logic [LIST_W-1:0] pick_rest;
  logic [3:0]        pick_cnt;
  logic [ADDR_W-1:0] offset;

  list_pick #(
    .LIST_W (LIST_W)
  ) u_list_pick (
    .list_i (list_q),
    .idx_o  (pick_idx),
    .rest_o (pick_rest),
    .cnt_o  (pick_cnt)
  );

  assign offset    = ADDR_W'({pick_cnt, 2'b00});
  assign mem_wdata = rf_rdata;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_STM;
      list_q    <= '0;
      rn_idx_q  <= '0;
      rn_val_q  <= '0;
      addr_q    <= '0;
      wb_q      <= '0;
      err_q     <= 1'b0;
      skip_wb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      list_q    <= list_d;
      rn_idx_q  <= rn_idx_d;
      rn_val_q  <= rn_val_d;
      addr_q    <= addr_d;
      wb_q      <= wb_d;
      err_q     <= err_d;
      skip_wb_q <= skip_wb_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    list_d    = list_q;
    rn_idx_d  = rn_idx_q;
    rn_val_d  = rn_val_q;
    addr_d    = addr_q;
    wb_d      = wb_q;
    err_d     = err_q;
    skip_wb_d = skip_wb_q;

    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    rf_raddr  = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    pc_load   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op_e'(op);
          list_d    = list;
          rn_idx_d  = rn_idx;
          rn_val_d  = rn_val;
          err_d     = 1'b0;
          // The list bit is cleared as it is walked, so decide LDM
          // writeback suppression from the original list here.
          skip_wb_d = (op_e'(op) == OP_LDM) && !rn_idx[3] && list[rn_idx[2:0]];
          state_d   = (list == '0) ? ST_DONE : ST_CALC;
        end
      end

      ST_CALC: begin
        busy    = 1'b1;
        addr_d  = (op_q == OP_PUSH) ? rn_val_q - offset : rn_val_q;
        wb_d    = (op_q == OP_PUSH) ? rn_val_q - offset : rn_val_q + offset;
        state_d = ST_XFER;
      end

      ST_XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = !op_is_load(op_q);
        mem_addr = addr_q;
        rf_raddr = op_is_load(op_q) ? 4'd0 : pick_idx;
        if (mem_ack) begin
          if (mem_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            list_d = pick_rest;
            addr_d = addr_q + ADDR_W'(4);
            if (op_is_load(op_q)) begin
              rf_we    = 1'b1;
              rf_waddr = pick_idx;
              rf_wdata = mem_rdata;
              pc_load  = (pick_idx == REG_PC);
            end
            if (pick_rest == '0) begin
              state_d = ST_WB;
            end
          end
        end
      end

      ST_WB: begin
        busy = 1'b1;
        if (!skip_wb_q) begin
          rf_we    = 1'b1;
          rf_waddr = rn_idx_q;
          rf_wdata = wb_q;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Multi-cycle sequencer for the Cortex-M0 load/store-multiple instructions: STM, LDM, PUSH and POP.
- Takes a 10-bit register list and a base value, then walks the list lowest register first, one word per memory handshake.
- Drives the register-file port and the memory port, then writes back the updated base register.
- Sits between the decoder and the register file / data-memory interface; the core stalls while busy=1.

Parameters:
- LIST_W, 10, list width: bits 7:0 = r0..r7, bit 8 = r14 (LR), bit 9 = r15 (PC).
- ADDR_W, 32, address and data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request from decoder; sampled only in IDLE
- op  in  2  operation: 00 STM (IA, writeback), 01 LDM (IA), 10 PUSH, 11 POP
- list  in  10  register list
- rn_idx  in  4  base register index (13 for PUSH/POP)
- rn_val  in  32  base register value
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address
- mem_wdata  out  32  store data (mirrors rf_rdata)
- mem_ack  in  1  transfer complete
- mem_err  in  1  bus fault; valid only with mem_ack
- mem_rdata  in  32  load data
- rf_raddr  out  4  register read index (stores)
- rf_rdata  in  32  register read data, combinational from rf_raddr
- rf_we  out  1  register write strobe (loads and writeback)
- rf_waddr  out  4  register write index
- rf_wdata  out  32  register write data
- pc_load  out  1  pulses with the rf_we that loads r15
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: transfer aborted by mem_err

Behaviour:
- Reset (synchronous, rst_n=0): state=IDLE. mem_req, mem_we, rf_we, pc_load, busy, done and err are 0. mem_addr, rf_raddr, rf_waddr, rf_wdata and all internal list/address registers are 0. Reset mid-transfer drops mem_req immediately; no writeback occurs.
- States: IDLE -> CALC -> XFER -> WB -> DONE -> IDLE.
- IDLE:
  - On start=1, latch list, op, rn_idx and rn_val, then go to CALC.
  - If list==0, go directly to DONE: no memory access, no writeback.
- CALC (1 cycle):
  - cnt = popcount(list), 0..10. Offset = cnt*4, computed as a 32-bit value.
  - Start address = rn_val - offset for PUSH; rn_val for STM, LDM and POP.
  - Writeback value = rn_val - offset for PUSH; rn_val + offset otherwise.
  - Arithmetic is modulo 2^32; wrap is not flagged.
- XFER:
  - mem_req=1. mem_addr = current address. Index = lowest set bit of the remaining list, encoded as 0..7, 14 or 15.
  - Stores: mem_we=1, rf_raddr = index, mem_wdata = rf_rdata.
  - mem_req, mem_addr, mem_we and mem_wdata hold stable until mem_ack.
  - On the ack cycle:
    - Clear the lowest set bit; address += 4.
    - Loads: rf_we=1, rf_waddr = index, rf_wdata = mem_rdata; pc_load=1 if index==15.
  - mem_req may stay high back-to-back across acks.
  - When the remaining list becomes 0 after an ack, go to WB.
  - mem_ack with mem_err=1: no register write for that beat; go to DONE with err=1; skip WB.
- WB (1 cycle): rf_we=1, rf_waddr = latched rn_idx, rf_wdata = writeback value.
  - Suppressed (rf_we=0) for LDM when bit rn_idx of the list is set (rn_idx <= 7).
- DONE: done=1 for one cycle (err as set during XFER), then IDLE. busy falls in the same cycle done pulses.
- Latency: one access with single-cycle ack gives start -> done in 4 cycles. n accesses give 3+n cycles.
- start while busy is ignored; nothing is queued.
- An op=PUSH list containing bit 9, or an op=POP list containing bit 8, is processed as given; the decoder is responsible for legality.

Decomposition:
- Shared package cm0_pkg holds:
  - op encodings: OP_STM, OP_LDM, OP_PUSH, OP_POP
  - state enum
  - REG_SP=13, REG_LR=14, REG_PC=15
  - LIST_W
- One sub-module, list_pick: purely combinational; outputs lowest-set-bit index (4-bit encoded), list with that bit cleared, and popcount. It is instantiated once.

Test Plan:
- STM: rn_idx=2, rn_val=0x100, list=0x00B (r0,r1,r3), ack every cycle -> stores to 0x100/0x104/0x108 reading r0/r1/r3; WB r2=0x10C; done at cycle 6.
- PUSH: rn_val=0x2000_0400, list=0x110 (r4,LR) -> stores r4@0x2000_03F8, r14@0x2000_03FC; WB r13=0x2000_03F8.
- POP: rn_val=0x3F8, list=0x201 (r0,PC), ack delayed 2 cycles each -> mem_req/addr held stable while waiting; r0 loaded from 0x3F8; r15 loaded from 0x3FC with pc_load=1; WB r13=0x400.
- LDM with base in list: rn_idx=1, list=0x006 -> r1 and r2 loaded; no WB rf_we.
- Faults and reset: list=0 -> done one cycle after start, no mem_req. mem_err on 2nd beat -> done with err=1, no WB. rst_n=0 mid-XFER -> all outputs 0 next cycle.
- start pulsed while busy -> ignored, current operation completes unchanged.
